// File: rtl/fifo_line_reader.sv
// Byte-FIFO read-side consumer: pops one byte per two cycles and assembles LF- or length-terminated lines.
// Optional build macro FIFO_LINE_READER_CR_STRIP_EN discards captured 8'h0D bytes.
module fifo_line_reader #(
   parameter int MAX_LEN = 50,
   parameter int LEN_W   = $clog2(MAX_LEN + 1)
) (
   input  logic                 read_clk,
   input  logic                 rst_n,
   input  logic                 empty,
   input  logic [7:0]           data_out,
   output logic                 read_en,
   output logic [8*MAX_LEN-1:0] line_data,
   output logic [LEN_W-1:0]     line_len,
   output logic                 line_valid,
   input  logic                 line_ready,
   output logic                 truncated,
   output logic [15:0]          line_count
);

   typedef enum logic {FILL, HOLD} state_t;

   localparam logic [LEN_W-1:0] MAX_LEN_L = LEN_W'(MAX_LEN);

   state_t           state;
   logic             run;
   logic             pend;
   logic             is_lf;
   logic             is_drop;
   logic [LEN_W-1:0] len_next;

   // run stays low through reset so no pop can be requested while rst_n is asserted
   assign read_en  = run && (state == FILL) && !pend && !empty;
   assign is_lf    = (data_out == 8'h0A);
   assign len_next = line_len + 1'b1;

`ifdef FIFO_LINE_READER_CR_STRIP_EN
   assign is_drop = (data_out == 8'h0D);
`else
   assign is_drop = 1'b0;
`endif

   always_ff @(posedge read_clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= FILL;
         run        <= 1'b0;
         pend       <= 1'b0;
         line_data  <= '0;
         line_len   <= '0;
         line_valid <= 1'b0;
         truncated  <= 1'b0;
         line_count <= '0;
      end else begin
         run <= 1'b1;
         case (state)
            FILL: begin
               // pop stage: a request marks one byte in flight
               if (read_en) begin
                  pend <= 1'b1;
               // capture stage: data_out holds the byte popped on the previous edge
               end else if (pend) begin
                  pend <= 1'b0;
                  if (is_lf) begin
                     line_valid <= 1'b1;
                     truncated  <= 1'b0;
                     state      <= HOLD;
                  end else if (!is_drop) begin
                     for (int i = 0; i < MAX_LEN; i++) begin
                        if (line_len == LEN_W'(i)) line_data[8*i +: 8] <= data_out;
                     end
                     line_len <= len_next;
                     if (len_next == MAX_LEN_L) begin
                        line_valid <= 1'b1;
                        truncated  <= 1'b1;
                        state      <= HOLD;
                     end
                  end
               end
            end
            HOLD: begin
               if (line_valid && line_ready) begin
                  line_valid <= 1'b0;
                  truncated  <= 1'b0;
                  line_len   <= '0;
                  line_data  <= '0;
                  line_count <= line_count + 16'd1;
                  state      <= FILL;
               end
            end
            default: state <= FILL;
         endcase
      end
   end

endmodule

// File: tb/tb_fifo_line_reader.sv
// Directed and randomized bench for fifo_line_reader with a byte-stream line model and a queue-based FIFO.
`timescale 1ns/1ps
module tb_fifo_line_reader;
   localparam int MAX_LEN = 50;
   localparam int LEN_W   = $clog2(MAX_LEN + 1);
   localparam int DW      = 8 * MAX_LEN;

   logic             read_clk   = 1'b0;
   logic             rst_n      = 1'b1;
   logic             empty      = 1'b1;
   logic             line_ready = 1'b0;
   logic [7:0]       data_out   = 8'h00;
   logic             read_en;
   logic             line_valid;
   logic             truncated;
   logic [DW-1:0]    line_data;
   logic [LEN_W-1:0] line_len;
   logic [15:0]      line_count;

   typedef struct {
      logic [DW-1:0] data;
      int            len;
      bit            trunc;
   } line_t;

   int            vectors     = 0;
   int            miscompares = 0;
   byte unsigned  fifo_q[$];
   byte unsigned  src_q[$];
   line_t         exp_q[$];
   logic [DW-1:0] cur_data    = '0;
   int            cur_len     = 0;
   int            exp_count   = 0;
   int            hold_fifo   = -1;
   bit            last_pop    = 1'b0;
   byte unsigned  last_byte   = 8'h00;

   always #5 read_clk = ~read_clk;

   fifo_line_reader #(.MAX_LEN(MAX_LEN)) dut (
      .read_clk   (read_clk),
      .rst_n      (rst_n),
      .empty      (empty),
      .data_out   (data_out),
      .read_en    (read_en),
      .line_data  (line_data),
      .line_len   (line_len),
      .line_valid (line_valid),
      .line_ready (line_ready),
      .truncated  (truncated),
      .line_count (line_count)
   );

   task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Line model: splits the byte stream into lines at LF or at MAX_LEN stored bytes.
   function automatic void emit(input bit tr);
      line_t l;
      l.data  = cur_data;
      l.len   = cur_len;
      l.trunc = tr;
      exp_q.push_back(l);
      cur_data = '0;
      cur_len  = 0;
   endfunction

   function automatic void model_add(input byte unsigned b);
`ifdef FIFO_LINE_READER_CR_STRIP_EN
      if (b == 8'h0D) return;
`endif
      if (b == 8'h0A) begin
         emit(1'b0);
      end else begin
         cur_data[8*cur_len +: 8] = b;
         cur_len++;
         if (cur_len == MAX_LEN) emit(1'b1);
      end
   endfunction

   task automatic fifo_push(input byte unsigned b);
      fifo_q.push_back(b);
      empty = 1'b0;
   endtask

   task automatic send(input byte unsigned b);
      fifo_push(b);
      model_add(b);
   endtask

   task automatic send_slow(input byte unsigned b);
      src_q.push_back(b);
      model_add(b);
   endtask

   // One clock: sample read_en mid-cycle, model the FIFO pop, then trickle slow bytes in.
   task automatic tick();
      bit pop;
      @(negedge read_clk);
      pop = read_en;
      @(posedge read_clk);
      #1;
      if (pop) begin
         chk("pop_spacing", last_pop, 0);
         chk("pop_nonempty", fifo_q.size() != 0, 1);
         if (fifo_q.size() != 0) begin
            last_byte = fifo_q.pop_front();
            data_out  = last_byte;
         end
      end
      last_pop = pop;
      if (src_q.size() != 0 && $urandom_range(0, 2) == 0) fifo_q.push_back(src_q.pop_front());
      empty = (fifo_q.size() == 0);
      #1;
   endtask

   task automatic check_line(input int hold);
      line_t e;
      int    n;
      n = 0;
      while (line_valid !== 1'b1 && n < 3000) begin
         tick();
         n++;
      end
      chk("line_valid_wait", line_valid, 1);
      if (line_valid !== 1'b1) return;
      chk("line_expected", exp_q.size() != 0, 1);
      if (exp_q.size() == 0) return;
      e = exp_q.pop_front();
      chk("line_len", line_len, e.len);
      chk("line_data", line_data, e.data);
      chk("truncated", truncated, e.trunc);
      chk("line_count", line_count, exp_count[15:0]);
      for (int i = 0; i < hold; i++) begin
         tick();
         chk("hold_read_en", read_en, 0);
         chk("hold_valid", line_valid, 1);
         if (hold_fifo >= 0) chk("hold_fifo_count", fifo_q.size(), hold_fifo);
      end
      line_ready = 1'b1;
      tick();
      line_ready = 1'b0;
      exp_count++;
      chk("valid_drop", line_valid, 0);
      chk("count_inc", line_count, exp_count[15:0]);
      chk("len_clear", line_len, 0);
      chk("data_clear", line_data, 0);
      chk("truncated_clear", truncated, 0);
      chk("reopen_read_en", read_en, fifo_q.size() != 0);
   endtask

   task automatic check_reset_outputs(input string tag);
      chk({tag, "_read_en"}, read_en, 0);
      chk({tag, "_valid"}, line_valid, 0);
      chk({tag, "_len"}, line_len, 0);
      chk({tag, "_data"}, line_data, 0);
      chk({tag, "_trunc"}, truncated, 0);
      chk({tag, "_count"}, line_count, 0);
   endtask

   initial begin
      int           n;
      int           len;
      byte unsigned b;

      // Reset with a lone LF already waiting: nothing may be popped during reset.
      #2 rst_n = 1'b0;
      fifo_push(8'h0A);
      tick();
      tick();
      check_reset_outputs("reset");
      rst_n = 1'b1;
      model_add(8'h0A);
      check_line(0);

      // "HI\n": six cycles from first pop to line_valid.
      send(8'h48); send(8'h49); send(8'h0A);
      n = 0;
      do begin
         tick();
         n++;
      end while (line_valid !== 1'b1 && n < 50);
      chk("hi_latency", n, 6);
      check_line(0);

      // 50 x 'A' truncates, then "B\n".
      for (int i = 0; i < MAX_LEN; i++) send(8'h41);
      send(8'h42); send(8'h0A);
      check_line(0);
      check_line(0);

      // Truncated line followed directly by LF gives an empty line.
      for (int i = 0; i < MAX_LEN; i++) send(8'h5A);
      send(8'h0A);
      check_line(0);
      check_line(0);

      // Backpressure: consumer stalls 10 cycles, second line stays in the FIFO.
      send(8'h41); send(8'h0A); send(8'h43); send(8'h0A);
      hold_fifo = 2;
      check_line(10);
      hold_fifo = -1;
      check_line(0);

      // CR handling depends on the build macro.
      send(8'h41); send(8'h0D); send(8'h0A);
      check_line(2);

      // line_ready while no line is held has no effect.
      line_ready = 1'b1;
      tick();
      tick();
      line_ready = 1'b0;
      chk("ready_ignored_count", line_count, exp_count[15:0]);
      chk("ready_ignored_valid", line_valid, 0);

      // Reset while 8'h55 is in flight: the byte is lost and a fresh line starts.
      fifo_push(8'h55); fifo_push(8'h41); fifo_push(8'h0A);
      n = 0;
      do begin
         tick();
         n++;
      end while (!(last_pop && last_byte == 8'h55) && n < 20);
      chk("pop55_seen", last_pop && last_byte == 8'h55, 1);
      rst_n = 1'b0;
      #1;
      check_reset_outputs("midreset");
      cur_data  = '0;
      cur_len   = 0;
      exp_count = 0;
      exp_q.delete();
      model_add(8'h41);
      model_add(8'h0A);
      tick();
      tick();
      rst_n = 1'b1;
      check_line(0);

      // Randomized lines trickled into the FIFO with gaps and random stalls.
      for (int l = 0; l < 20; l++) begin
         len = $urandom_range(0, 60);
         for (int i = 0; i < len; i++) begin
            if ($urandom_range(0, 15) == 0) b = 8'h0D;
            else b = 8'($urandom_range(32, 126));
            send_slow(b);
         end
         if ($urandom_range(0, 3) != 0) send_slow(8'h0A);
      end
      if (cur_len != 0) send_slow(8'h0A);
      n = 0;
      while (exp_q.size() != 0 && n < 200) begin
         check_line($urandom_range(0, 3));
         n++;
      end
      chk("model_drained", exp_q.size(), 0);
      chk("fifo_drained", fifo_q.size() + src_q.size(), 0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
